// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, fetch FIFO entry type and small arithmetic helpers for the IF stage.
package instr_fetch_unit_pkg;

  localparam int PC_W       = 10;
  localparam int INSTR_W    = 16;
  localparam int BOFS_W     = 6;
  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = 2;

  localparam logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Wraps modulo 2^PC_W by construction.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0]   pc,
    input logic [BOFS_W-1:0] ofs
  );
    return pc + PC_ONE + {{(PC_W-BOFS_W){ofs[BOFS_W-1]}}, ofs};
  endfunction

  function automatic logic [15:0] sat_add16(
    input logic [15:0] acc,
    input logic [2:0]  inc
  );
    logic [16:0] sum;
    sum = {1'b0, acc} + {14'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_skid_fifo: 2-entry {pc,instr} buffer between the ROM response and the decoder.
module fetch_skid_fifo
  import instr_fetch_unit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic [OCC_W-1:0] o_occ
);

  fetch_entry_t     r_mem [FIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    w_do_pop  = i_pop & (r_occ != 2'd0);
    // A push into a full FIFO is only accepted when the same-cycle pop frees a slot.
    w_do_push = i_push & ((r_occ != 2'd2) | w_do_pop);
    o_head    = r_mem[r_rptr];
    o_valid   = (r_occ != 2'd0);
    o_occ     = r_occ;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= r_occ + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, ROM request issue, epoch-based wrong-path kill and redirect handling.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  output logic [PC_W-1:0]    oRomAddr,
  input  logic [INSTR_W-1:0] iRomData,
  output logic [INSTR_W-1:0] oInstr,
  output logic [PC_W-1:0]    oPC,
  output logic               oValid,
  input  logic               iReady,
  input  logic               iJmpEnable,
  input  logic [PC_W-1:0]    iJmpDir,
  input  logic               iBranchEnable,
  input  logic [PC_W-1:0]    iBranchPC,
  input  logic [BOFS_W-1:0]  iBranchOffset
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        oStallCnt,
  output logic [15:0]        oFlushCnt
`endif
);

  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_inflight;
  logic [PC_W-1:0]  r_tag;
  logic             r_epoch;
  logic             r_req_epoch;

  logic             w_redirect;
  logic [PC_W-1:0]  w_target;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [2:0]       w_budget;
  logic [OCC_W-1:0] w_occ;
  logic             w_fifo_valid;
  fetch_entry_t     w_fifo_head;
  fetch_entry_t     w_fifo_in;

  always_comb begin
    w_redirect = iBranchEnable | iJmpEnable;
    // EX branch is older than the ID jump, so it takes priority.
    w_target   = iBranchEnable ? branch_target(iBranchPC, iBranchOffset) : iJmpDir;

    if (Reset) begin
      oRomAddr = RESET_VEC;
      oValid   = 1'b0;
      oPC      = {PC_W{1'b0}};
      oInstr   = {INSTR_W{1'b0}};
    end else begin
      oRomAddr = w_redirect ? w_target : r_fetch_pc;
      oValid   = w_fifo_valid;
      oPC      = w_fifo_head.pc;
      oInstr   = w_fifo_head.instr;
    end

    w_pop    = oValid & iReady & ~w_redirect;
    w_budget = {1'b0, w_occ} + {2'b00, r_inflight};
    w_issue  = ~Reset & (w_redirect | ((w_budget - {2'b00, w_pop}) < 3'd2));
    // The response is kept only if no redirect has moved the epoch since it was issued.
    w_push   = ~Reset & r_inflight & (r_req_epoch == r_epoch) & ~w_redirect;

    w_fifo_in.pc    = r_tag;
    w_fifo_in.instr = iRomData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_fetch_pc  <= RESET_VEC;
      r_inflight  <= 1'b0;
      r_tag       <= {PC_W{1'b0}};
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag       <= oRomAddr;
        r_fetch_pc  <= oRomAddr + PC_ONE;
        r_req_epoch <= w_redirect ? ~r_epoch : r_epoch;
      end
      if (w_redirect) begin
        r_epoch <= ~r_epoch;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_fifo_in),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_occ   (w_occ)
  );

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (oValid && !iReady) begin
        r_stall_cnt <= sat_add16(r_stall_cnt, 3'd1);
      end
      // Discarded words: everything buffered plus the response killed this cycle.
      if (w_redirect) begin
        r_flush_cnt <= sat_add16(r_flush_cnt, w_budget);
      end
    end
  end

  assign oStallCnt = r_stall_cnt;
  assign oFlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: ROM model k -> k+0x100, expected PCs queued at stimulus time.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [PC_W-1:0]    oRomAddr;
  logic [INSTR_W-1:0] iRomData = 16'h0000;
  logic [INSTR_W-1:0] oInstr;
  logic [PC_W-1:0]    oPC;
  logic               oValid;
  logic               iReady;
  logic               iJmpEnable;
  logic [PC_W-1:0]    iJmpDir;
  logic               iBranchEnable;
  logic [PC_W-1:0]    iBranchPC;
  logic [BOFS_W-1:0]  iBranchOffset;
`ifdef IF_PERF_CNT_EN
  logic [15:0]        oStallCnt;
  logic [15:0]        oFlushCnt;
  logic [15:0]        cnt_before;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [PC_W-1:0] sb_q[$];
  logic [PC_W-1:0] sb_last;
  logic            mon_en = 1'b0;
  logic            found;

  instr_fetch_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oRomAddr      (oRomAddr),
    .iRomData      (iRomData),
    .oInstr        (oInstr),
    .oPC           (oPC),
    .oValid        (oValid),
    .iReady        (iReady),
    .iJmpEnable    (iJmpEnable),
    .iJmpDir       (iJmpDir),
    .iBranchEnable (iBranchEnable),
    .iBranchPC     (iBranchPC),
    .iBranchOffset (iBranchOffset)
`ifdef IF_PERF_CNT_EN
    ,
    .oStallCnt     (oStallCnt),
    .oFlushCnt     (oFlushCnt)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) iRomData <= {6'b000000, oRomAddr} + 16'h0100;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_refill(input logic [PC_W-1:0] start);
    sb_q.delete();
    for (int i = 0; i < 8; i++) sb_q.push_back(start + PC_W'(i));
    sb_last = start + PC_W'(7);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Every accepted (non-redirect) handshake must match the next queued PC.
  always @(negedge Clock) begin
    if (mon_en && !Reset && oValid && iReady && !iJmpEnable && !iBranchEnable) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underrun", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [PC_W-1:0] exp_pc;
        exp_pc = sb_q.pop_front();
        check_eq("hs_pc", 32'(oPC), 32'(exp_pc));
        check_eq("hs_instr", 32'(oInstr), 32'({6'b000000, exp_pc} + 16'h0100));
        sb_last = sb_last + PC_ONE;
        sb_q.push_back(sb_last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; iReady = 1'b0; iJmpEnable = 1'b0; iJmpDir = 10'd0;
    iBranchEnable = 1'b0; iBranchPC = 10'd0; iBranchOffset = 6'd0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_eq("rst_valid", 32'(oValid), 32'd0);
    check_eq("rst_pc", 32'(oPC), 32'd0);
    check_eq("rst_instr", 32'(oInstr), 32'd0);
    check_eq("rst_addr", 32'(oRomAddr), 32'd0);

    // Reset release and start-up latency.
    tick(); Reset = 1'b0; iReady = 1'b1; sb_refill(10'd0); mon_en = 1'b1;
    @(negedge Clock); check_eq("c0_addr", 32'(oRomAddr), 32'd0); check_eq("c0_valid", 32'(oValid), 32'd0);
    @(negedge Clock); check_eq("c1_addr", 32'(oRomAddr), 32'd1); check_eq("c1_valid", 32'(oValid), 32'd0);
    @(negedge Clock); check_eq("c2_addr", 32'(oRomAddr), 32'd2); check_eq("c2_valid", 32'(oValid), 32'd1);
    check_eq("c2_pc", 32'(oPC), 32'd0);

    // Stall at PC 3.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (oValid && oPC == 10'd3) begin found = 1'b1; iReady = 1'b0; end
    end
    check_eq("find_pc3", 32'(found), 32'd1);
`ifdef IF_PERF_CNT_EN
    cnt_before = oStallCnt;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check_eq("stall_valid", 32'(oValid), 32'd1);
      check_eq("stall_pc", 32'(oPC), 32'd3);
      check_eq("stall_instr", 32'(oInstr), 32'h103);
      if (i == 3) begin
        check_eq("stall_occ", 32'(dut.w_occ), 32'd2);
        check_eq("stall_issue", 32'(dut.w_issue), 32'd0);
      end
      tick();
    end
`ifdef IF_PERF_CNT_EN
    check_eq("stall_cnt", 32'(oStallCnt - cnt_before), 32'd5);
`endif
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock); check_eq("resume_valid", 32'(oValid), 32'd1);
    end

    // Jump to 0x200 while streaming.
    tick(); iJmpEnable = 1'b1; iJmpDir = 10'h200; sb_refill(10'h200);
    @(negedge Clock); check_eq("jmp_addr", 32'(oRomAddr), 32'h200);
    tick(); iJmpEnable = 1'b0;
    @(negedge Clock); check_eq("jmp_gap", 32'(oValid), 32'd0);
    tick();
    @(negedge Clock); check_eq("jmp_valid", 32'(oValid), 32'd1); check_eq("jmp_pc", 32'(oPC), 32'h200);

    // Branch and jump together: branch 5 + 1 - 3 = 3 wins.
    repeat (3) tick();
    iBranchEnable = 1'b1; iBranchPC = 10'd5; iBranchOffset = 6'h3D;
    iJmpEnable = 1'b1; iJmpDir = 10'h100; sb_refill(10'd3);
    @(negedge Clock); check_eq("both_addr", 32'(oRomAddr), 32'd3);
    tick(); iBranchEnable = 1'b0; iJmpEnable = 1'b0;
    @(negedge Clock); check_eq("both_gap", 32'(oValid), 32'd0);
    tick();
    @(negedge Clock); check_eq("both_pc", 32'(oPC), 32'd3);

    // Wrapping branch target: 1023 + 1 + 2 = 2.
    repeat (3) tick();
    iBranchEnable = 1'b1; iBranchPC = 10'd1023; iBranchOffset = 6'd2; sb_refill(10'd2);
    @(negedge Clock); check_eq("wrap_addr", 32'(oRomAddr), 32'd2);
    tick(); iBranchEnable = 1'b0;
    tick();
    @(negedge Clock); check_eq("wrap_pc", 32'(oPC), 32'd2);

    // Back-to-back: jump then branch (10 + 1 + 5 = 16); jump target never delivered.
    repeat (4) tick();
`ifdef IF_PERF_CNT_EN
    cnt_before = oFlushCnt;
`endif
    iJmpEnable = 1'b1; iJmpDir = 10'h200; sb_refill(10'h200);
    tick(); iJmpEnable = 1'b0;
    iBranchEnable = 1'b1; iBranchPC = 10'd10; iBranchOffset = 6'd5; sb_refill(10'd16);
    @(negedge Clock); check_eq("b2b_addr", 32'(oRomAddr), 32'd16);
    tick(); iBranchEnable = 1'b0;
    @(negedge Clock); check_eq("b2b_gap", 32'(oValid), 32'd0);
    tick();
    @(negedge Clock); check_eq("b2b_valid", 32'(oValid), 32'd1); check_eq("b2b_pc", 32'(oPC), 32'd16);
`ifdef IF_PERF_CNT_EN
    check_eq("flush_cnt", 32'(oFlushCnt - cnt_before), 32'd3);
`endif

    // Reset for one cycle in the middle of a stall with a full FIFO.
    repeat (3) tick();
    iReady = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_occ", 32'(dut.w_occ), 32'd2);
    Reset = 1'b1;
    @(negedge Clock); check_eq("mid_rst_valid", 32'(oValid), 32'd0); check_eq("mid_rst_addr", 32'(oRomAddr), 32'd0);
    tick(); Reset = 1'b0; iReady = 1'b1; sb_refill(10'd0);
    @(negedge Clock); check_eq("r0_addr", 32'(oRomAddr), 32'd0); check_eq("r0_valid", 32'(oValid), 32'd0);
    @(negedge Clock); check_eq("r1_valid", 32'(oValid), 32'd0);
    @(negedge Clock); check_eq("r2_valid", 32'(oValid), 32'd1); check_eq("r2_pc", 32'(oPC), 32'd0);
    repeat (6) tick();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
